// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and types for the display path.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  function automatic int unsigned timing_total(
    input int unsigned active,
    input int unsigned fp,
    input int unsigned sync,
    input int unsigned bp
  );
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned DEF_H_TOTAL =
    timing_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned DEF_V_TOTAL =
    timing_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register of configurable width and depth.
// Every stage resets to RST_VAL; q is the input from DEPTH enabled edges ago.
module sync_delay_line #(
  parameter int unsigned     WIDTH   = 1,
  parameter int unsigned     DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d = stage_q;
    if (en) begin
      stage_d[0] = d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: registered pixel coordinates, syncs and DE,
// plus PIPE_DELAY-aligned copies. Define VGA_FRAME_COUNT_EN to add frameCount.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter bit          SYNC_POL   = SYNC_ACTIVE_LOW,
  parameter int unsigned PIPE_DELAY = 3
) (
  input  logic               vgaClk,
  input  logic               rst,
  input  logic               enable,
  output logic [COORD_W-1:0] pixelX,
  output logic [COORD_W-1:0] pixelY,
  output logic               videoOn,
  output logic               hsync,
  output logic               vsync,
  output logic               lineStart,
  output logic               frameStart,
`ifdef VGA_FRAME_COUNT_EN
  output logic [15:0]        frameCount,
`endif
  output logic               hsyncD,
  output logic               vsyncD,
  output logic               videoOnD
);

  localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  if (H_TOTAL > 1024) begin : g_bad_h_total
    $error("vga_sync_gen: H_TOTAL exceeds 10-bit counter range");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("vga_sync_gen: V_TOTAL exceeds 10-bit counter range");
  end
  if (PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_bad_pipe_delay
    $error("vga_sync_gen: PIPE_DELAY must be in 1..8");
  end

  coord_t h_cnt_q, h_cnt_d;
  coord_t v_cnt_q, v_cnt_d;
  coord_t pixel_x_q, pixel_x_d;
  coord_t pixel_y_q, pixel_y_d;
  logic   video_on_q, video_on_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   line_start_q, line_start_d;
  logic   frame_start_q, frame_start_d;
  logic   at_frame_origin;

  assign at_frame_origin = (h_cnt_q == '0) && (v_cnt_q == '0);

  // Outputs sample the current count, then the count advances: edge N shows position N-1.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    video_on_d    = video_on_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (enable) begin
      pixel_x_d     = h_cnt_q;
      pixel_y_d     = v_cnt_q;
      video_on_d    = (32'(h_cnt_q) < H_ACTIVE) && (32'(v_cnt_q) < V_ACTIVE);
      hsync_d       = ((32'(h_cnt_q) >= HS_START) && (32'(h_cnt_q) < HS_END))
                      ? SYNC_POL : ~SYNC_POL;
      vsync_d       = ((32'(v_cnt_q) >= VS_START) && (32'(v_cnt_q) < VS_END))
                      ? SYNC_POL : ~SYNC_POL;
      line_start_d  = (h_cnt_q == '0);
      frame_start_d = at_frame_origin;
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + coord_t'(1);
      end else begin
        h_cnt_d = h_cnt_q + coord_t'(1);
      end
    end
  end

  always_ff @(posedge vgaClk) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      video_on_q    <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixelX     = pixel_x_q;
  assign pixelY     = pixel_y_q;
  assign videoOn    = video_on_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign lineStart  = line_start_q;
  assign frameStart = frame_start_q;

  // Feeding the registered outputs makes q equal the source from exactly DEPTH enabled edges earlier.
  logic [2:0] dly_q;

  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
  ) u_sync_delay_line (
    .clk (vgaClk),
    .rst (rst),
    .en  (enable),
    .d   ({hsync_q, vsync_q, video_on_q}),
    .q   (dly_q)
  );

  assign hsyncD   = dly_q[2];
  assign vsyncD   = dly_q[1];
  assign videoOnD = dly_q[0];

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic        frame_seen_q, frame_seen_d;

  // Frame 0 reads 0: the first origin after reset only arms the counter.
  always_comb begin
    frame_count_d = frame_count_q;
    frame_seen_d  = frame_seen_q;
    if (enable && at_frame_origin) begin
      frame_seen_d = 1'b1;
      if (frame_seen_q) begin
        frame_count_d = frame_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge vgaClk) begin
    if (rst) begin
      frame_count_q <= '0;
      frame_seen_q  <= 1'b0;
    end else begin
      frame_count_q <= frame_count_d;
      frame_seen_q  <= frame_seen_d;
    end
  end

  assign frameCount = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized-enable bench for vga_sync_gen on a reduced raster, checked
// against a closed-form model of position versus enabled edges since reset.
module tb_vga_sync_gen;

  localparam int unsigned HA = 12, HF = 3, HS = 4, HB = 5;
  localparam int unsigned VA = 8, VF = 2, VS = 2, VB = 3;
  localparam int unsigned PD = 3;
  localparam bit          POL = 1'b0;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;

  logic       vgaClk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [9:0] pixelX, pixelY;
  logic       videoOn, hsync, vsync, lineStart, frameStart;
  logic       hsyncD, vsyncD, videoOnD;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frameCount;
`endif

  vga_sync_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (POL), .PIPE_DELAY (PD)
  ) dut (
    .vgaClk     (vgaClk),
    .rst        (rst),
    .enable     (enable),
    .pixelX     (pixelX),
    .pixelY     (pixelY),
    .videoOn    (videoOn),
    .hsync      (hsync),
    .vsync      (vsync),
    .lineStart  (lineStart),
    .frameStart (frameStart),
`ifdef VGA_FRAME_COUNT_EN
    .frameCount (frameCount),
`endif
    .hsyncD     (hsyncD),
    .vsyncD     (vsyncD),
    .videoOnD   (videoOnD)
  );

  always #5 vgaClk = ~vgaClk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state: enabled edges since reset, and whether the last edge was enabled.
  int unsigned k = 0;
  bit          last_en = 1'b0;

  typedef struct {
    int unsigned x;
    int unsigned y;
    bit          vo;
    bit          hs;
    bit          vs;
  } ras_t;

  function automatic ras_t ras_at(input int unsigned n);
    ras_t r;
    int unsigned p;
    if (n == 0) begin
      r.x = 0; r.y = 0; r.vo = 1'b0; r.hs = ~POL; r.vs = ~POL;
    end else begin
      p    = (n - 1) % FRAME;
      r.x  = p % HT;
      r.y  = p / HT;
      r.vo = (r.x < HA) && (r.y < VA);
      r.hs = (r.x >= HA + HF && r.x < HA + HF + HS) ? POL : ~POL;
      r.vs = (r.y >= VA + VF && r.y < VA + VF + VS) ? POL : ~POL;
    end
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic check_outputs();
    ras_t r, d;
    r = ras_at(k);
    d = ras_at(k >= PD ? k - PD : 0);
    check_val("pixelX", 32'(pixelX), r.x);
    check_val("pixelY", 32'(pixelY), r.y);
    check_val("videoOn", 32'(videoOn), 32'(r.vo));
    check_val("hsync", 32'(hsync), 32'(r.hs));
    check_val("vsync", 32'(vsync), 32'(r.vs));
    check_val("lineStart", 32'(lineStart), 32'(last_en && r.x == 0));
    check_val("frameStart", 32'(frameStart), 32'(last_en && r.x == 0 && r.y == 0));
    check_val("hsyncD", 32'(hsyncD), 32'(d.hs));
    check_val("vsyncD", 32'(vsyncD), 32'(d.vs));
    check_val("videoOnD", 32'(videoOnD), 32'(d.vo));
`ifdef VGA_FRAME_COUNT_EN
    check_val("frameCount", 32'(frameCount), (k == 0) ? 0 : (((k - 1) / FRAME) % 65536));
`endif
  endtask

  task automatic step(input bit r, input bit en);
    rst    = r;
    enable = en;
    @(posedge vgaClk);
    if (r) begin
      k = 0;
      last_en = 1'b0;
    end else if (en) begin
      k++;
      last_en = 1'b1;
    end else begin
      last_en = 1'b0;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    ras_t cur;
    int unsigned guard;

    // Reset for five cycles; reset must override a high enable.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);

    // Continuous run across a frame wrap and into frame 1.
    for (int i = 0; i < FRAME + FRAME / 2; i++) step(1'b0, 1'b1);

    // Hold enable low for ten cycles at pixelX==5 (mid-line), then resume.
    guard = 0;
    cur = ras_at(k);
    while (cur.x != 5 && guard < 2 * HT) begin
      step(1'b0, 1'b1);
      cur = ras_at(k);
      guard++;
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);

    // Also stall right on a line start so a stretched pulse would show.
    guard = 0;
    cur = ras_at(k);
    while (cur.x != 0 && guard < 2 * HT) begin
      step(1'b0, 1'b1);
      cur = ras_at(k);
      guard++;
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    // Randomly gated enable over several frames.
    for (int i = 0; i < 3 * FRAME; i++) step(1'b0, $urandom_range(0, 3) != 0);

    // Single-cycle reset mid-frame once frame 2 or later is underway.
    guard = 0;
    cur = ras_at(k);
    while (!((k - 1) / FRAME >= 2 && cur.y == 5) && guard < 4 * FRAME) begin
      step(1'b0, 1'b1);
      cur = ras_at(k);
      guard++;
    end
    step(1'b1, 1'b1);
    for (int i = 0; i < 2 * FRAME + 20; i++) step(1'b0, 1'b1);

    // Reset while enable is low, then release with enable held low first.
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < FRAME; i++) step(1'b0, $urandom_range(0, 4) != 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
